sha256_padder: RTL
==================

# sha256_padder

Upstream front-end for the SHA-256 core. It accepts a message as a byte stream and applies SHA-256 padding: one 0x80 byte, zero fill, then the 64-bit big-endian message bit length. It emits the result as 512-bit blocks, sent as sixteen 32-bit big-endian words per block with a valid/ready handshake. The hash core consumes these words directly.

## Interface
- No parameters; widths are fixed by SHA-256.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  byte available on in_data
- in_ready  out  1  padder accepts a byte this cycle
- in_data  in  8  message byte
- in_last  in  1  qualifies the byte as the final one of the message
- in_nobyte  in  1  with in_last: in_data is not part of the message; used for zero-length messages or a terminator-only beat
- out_valid  out  1  out_word valid
- out_ready  in  1  downstream accepts the word
- out_word  out  32  padded message word; first byte of the word in [31:24]
- out_idx  out  4  word index within the block, 0..15
- out_blk_end  out  1  out_idx == 15
- out_msg_end  out  1  final word of the final block of the message

## Operation
- **Transfers.**
  - An input byte transfers when in_valid && in_ready.
  - An output word transfers when out_valid && out_ready.
- **Slot.** slot = !out_valid || out_ready. A byte, whether message or pad, enters the packer only when slot is 1.
- **Packer.**
  - 4-byte shift register plus a 2-bit byte lane counter.
  - The 4th byte loads out_word/out_idx/flags and sets out_valid on the next edge.
  - out_valid clears on transfer unless a new word loads in the same cycle.
- **Counters.**
  - pos[5:0]: byte position within the block; counts message and pad bytes; wraps 63 -> 0.
  - len[60:0]: message byte count; counts only message bytes.
  - bit length = {len, 3'b000}; len wraps silently mod 2^61.
- **States.**
  - **S_DATA**
    - in_ready = slot.
    - A byte accepted with in_last=0 is packed; pos and len increment.
    - A byte accepted with in_last=1, in_nobyte=0 is packed and counted, then go to S_PAD80.
    - in_last=1 with in_nobyte=1: nothing packed, go to S_PAD80.
  - **S_PAD80**
    - Inject 0x80 when slot.
    - Go to S_LEN if the new pos == 56; otherwise go to S_ZERO.
  - **S_ZERO**
    - Inject 0x00 each slot cycle while pos != 56.
    - Go to S_LEN when pos reaches 56. Crossing 63 -> 0 produces an extra block.
  - **S_LEN**
    - Inject 8 bytes of the bit length, most significant byte first, one per slot cycle.
    - The word built from the final byte carries out_msg_end=1.
    - After the 8th byte: len <- 0, pos is 0, go to S_DATA.
- **Padding-state input.** in_ready = 0 in S_PAD80, S_ZERO and S_LEN; in_valid is ignored there.
- **Reset.** reset low asynchronously sets:
  - state S_DATA
  - pos, len, lane counter = 0
  - out_valid, out_word, out_idx, out_blk_end, out_msg_end = 0
  - in_ready is forced 0 while reset is low.

## Timing
- A word completed by a byte transfer on edge N is presented with out_valid=1 after edge N (one-register latency).
- Throughput is 1 byte/cycle in and 1 word per 4 cycles out when out_ready=1. No bubbles are inserted at state transitions.
- Backpressure:
  - out_word, out_idx and the flags are held stable while out_valid && !out_ready.
  - The packer and padding sequencer freeze (slot=0).
- Examples with out_ready=1 held:
  - "abc" bytes on cycles 0..2: 0x80 on cycle 3; zeros on cycles 4..55; length on cycles 56..63; final word valid on cycle 64.
  - Zero-length message: 64 pad bytes.
- A new message may start in S_DATA on the cycle after the 8th length byte is injected.
- Releasing reset: in_ready may be 1 in the first cycle after deassertion.

## Test plan
- "abc", out_ready=1 -> words 0x61626380, then 14 x 0x00000000, then 0x00000018. out_blk_end and out_msg_end on word 15 only. Final out_valid on cycle 64.
- Empty message: in_valid, in_last and in_nobyte together -> 0x80000000, then 14 zeros, then 0x00000000. out_msg_end set on word 15.
- 55 bytes of 0x41 -> single block. Word 13 = 0x41414180, word 14 = 0, word 15 = 0x000001B8.
- 56 bytes of 0x41 -> two blocks.
  - Block 1: words 0..13 = 0x41414141, word 14 = 0x80000000, word 15 = 0, out_msg_end=0.
  - Block 2: words 0..14 = 0, word 15 = 0x000001C0, out_msg_end=1.
- 64-byte message immediately followed by "abc", with random out_ready at 30% duty:
  - Word sequences match the expected values exactly.
  - out_word is stable during every stall.
  - in_ready stays 0 throughout padding.
  - The second message's length word is 0x00000018.
- reset pulsed low mid-S_ZERO -> all outputs 0 immediately and in_ready=0. After release, "abc" pads correctly with length counted from zero.

Source files
------------

// File: rtl/sha256_padder.sv
// sha256_padder: SHA-256 message padding of a byte stream into 16-word 512-bit blocks
module sha256_padder (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  input  logic        in_nobyte,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_word,
  output logic [3:0]  out_idx,
  output logic        out_blk_end,
  output logic        out_msg_end
);
  localparam logic [1:0] S_DATA  = 2'd0;
  localparam logic [1:0] S_PAD80 = 2'd1;
  localparam logic [1:0] S_ZERO  = 2'd2;
  localparam logic [1:0] S_LEN   = 2'd3;
  logic [1:0]  r_state;
  logic [5:0]  r_pos;
  logic [60:0] r_len;
  logic [1:0]  r_lane;
  logic [23:0] r_sh;
  logic        w_slot, w_acc, w_msg, w_push, w_len_done;
  logic [7:0]  w_byte;
  logic [5:0]  w_pos_nx;
  logic [63:0] w_bits;
  assign w_slot     = !out_valid || out_ready;
  assign in_ready   = reset && r_state == S_DATA && w_slot;
  assign w_acc      = in_valid && in_ready;
  assign w_msg      = w_acc && !(in_last && in_nobyte);
  assign w_bits     = {r_len, 3'b000};
  assign w_pos_nx   = r_pos + 6'd1;
  assign w_len_done = r_state == S_LEN && w_slot && r_pos == 6'd63;
  // Choose the byte entering the packer this cycle: message data or padding
  always_comb begin
    w_push = (r_state == S_DATA) ? w_msg : w_slot;
    w_byte = (r_state == S_DATA)  ? in_data :
             (r_state == S_PAD80) ? 8'h80 :
             (r_state == S_ZERO)  ? 8'h00 :
             w_bits[{~r_pos[2:0], 3'b000} +: 8];
  end
  // Padding sequencer: state, block position and message length
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_DATA;
      r_pos   <= '0;
      r_len   <= '0;
    end else begin
      if (w_acc && in_last)
        r_state <= S_PAD80;
      else if (r_state == S_PAD80 && w_slot)
        r_state <= (w_pos_nx == 6'd56) ? S_LEN : S_ZERO;
      else if (r_state == S_ZERO && w_slot && w_pos_nx == 6'd56)
        r_state <= S_LEN;
      else if (w_len_done)
        r_state <= S_DATA;
      if (w_push)
        r_pos <= w_pos_nx;
      if (w_len_done)
        r_len <= '0;
      else if (w_msg)
        r_len <= r_len + 61'd1;
    end
  end
  // Packer: collect bytes, the fourth one loads the output word
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lane      <= '0;
      r_sh        <= '0;
      out_valid   <= 1'b0;
      out_word    <= '0;
      out_idx     <= '0;
      out_blk_end <= 1'b0;
      out_msg_end <= 1'b0;
    end else begin
      if (w_push) begin
        r_lane <= r_lane + 2'd1;
        r_sh   <= {r_sh[15:0], w_byte};
      end
      if (w_push && r_lane == 2'd3) begin
        out_valid   <= 1'b1;
        out_word    <= {r_sh, w_byte};
        out_idx     <= r_pos[5:2];
        out_blk_end <= r_pos[5:2] == 4'd15;
        out_msg_end <= w_len_done;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule
